router_ctrl: RTL and testbench
==============================

ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 SHALL have parameter: NUM_PORTS, 3, number of destination FIFOs (fixed at 3; address 2'b11 invalid).
REQ-002 SHALL have parameter: TIMEOUT, 30, idle-read cycles before a port's soft reset.
REQ-003 SHALL have ports, clock and reset first: clk in 1, single clock, all logic on rising edge; rstn in 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports: pkt_valid in 1, source byte valid; data_in in 8, source byte (header: [1:0] addr, [7:2] payload length).
REQ-005 SHALL have ports: fifo_full in 3 and fifo_empty in 3 (per-FIFO status); rd_en in 3 (destination read enables).
REQ-006 SHALL have ports: busy out 1 (source holds byte); dout out 8 (FIFO write data); write_enb out 3 (one-hot FIFO write); lfd_state out 1 (header tag).
REQ-007 SHALL have ports: soft_rst out 3 (per-FIFO soft reset pulse); vld_out out 3 (per-FIFO data available); err out 1 (parity error).

Function
REQ-008 SHALL implement states DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, CHECK_PARITY_ERROR, DROP_PACKET.
REQ-009 SHALL treat a byte as accepted on a rising edge where busy=0; busy, write_enb, dout, lfd_state SHALL be combinational from state and inputs.
REQ-010 DECODE_ADDRESS: busy=0; on pkt_valid latch addr and header into hdr_reg; addr=3 -> DROP_PACKET; fifo_empty[addr]=1 -> LOAD_FIRST_DATA; else -> WAIT_TILL_EMPTY.
REQ-011 WAIT_TILL_EMPTY: busy=1, no write; -> LOAD_FIRST_DATA when fifo_empty[addr]=1.
REQ-012 lfd_state SHALL be 1 exactly in the cycle whose next state is LOAD_FIRST_DATA (FIFOs delay lfd_state one cycle internally).
REQ-013 LOAD_FIRST_DATA: busy=1, write_enb[addr]=1, dout=hdr_reg; -> LOAD_DATA.
REQ-014 LOAD_DATA, fifo_full[addr]=1: busy=1, no write, -> FIFO_FULL_STATE.
REQ-015 LOAD_DATA, not full, pkt_valid=1: busy=0, write data_in, stay; pkt_valid=0: busy=0, write data_in as parity byte, -> CHECK_PARITY_ERROR.
REQ-016 FIFO_FULL_STATE: busy=1, no write; -> LOAD_DATA when fifo_full[addr]=0; source byte held, never lost.
REQ-017 CHECK_PARITY_ERROR: busy=1 one cycle; -> DECODE_ADDRESS.
REQ-018 DROP_PACKET: busy=0, no writes; -> DECODE_ADDRESS on first cycle with pkt_valid=0 (parity byte discarded); err unaffected.
REQ-019 vld_out[i] SHALL equal ~fifo_empty[i].
REQ-020 Per port: counter increments while vld_out[i]=1 and rd_en[i]=0, clears otherwise; at count TIMEOUT soft_rst[i] pulses 1 cycle and counter clears.
REQ-021 soft_rst[addr]=1 in WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA or FIFO_FULL_STATE SHALL abort the packet -> DECODE_ADDRESS next cycle, no further writes; other ports unaffected.
REQ-022 write_enb SHALL be one-hot or zero; dout SHALL be 0 when write_enb=0.

Reset
REQ-023 rstn=0 SHALL asynchronously force DECODE_ADDRESS, clear hdr_reg, addr, parity accumulator, err, all timeout counters.
REQ-024 During/after reset: busy=0, write_enb=0, dout=0, lfd_state=0, soft_rst=0, err=0; vld_out follows fifo_empty.
REQ-025 Reset mid-packet SHALL discard the packet; no write issued until a new header is accepted.

Configuration
REQ-026 Macro ROUTER_CTRL_PARITY_CHK_EN defined: running XOR of header and payload bytes; err registered 1 in CHECK_PARITY_ERROR if XOR != parity byte, held until next header accepted.
REQ-027 Macro undefined: no accumulator, err tied 0, LOAD_DATA parity cycle -> DECODE_ADDRESS directly (CHECK_PARITY_ERROR unreachable).

Structure
REQ-028 Package router_pkg SHALL hold the state enum, NUM_PORTS, ADDR_INVALID (2'b11), header field positions.
REQ-029 Sub-module router_ctrl_timeout (one port's watchdog counter plus soft_rst pulse) SHALL be instantiated NUM_PORTS times.

Verification
REQ-030 Header 8'h0D (addr1, len3), payload 11,22,33, parity = XOR, FIFO1 empty -> writes 0D,11,22,33,parity to port1; lfd_state 1 cycle before 0D; err=0.
REQ-031 Same packet, parity byte 8'h00 (wrong), macro defined -> err=1 after parity write until next header; macro undefined -> err=0.
REQ-032 Header addr2, fifo_empty[2]=0 for 5 cycles -> busy=1 five cycles, header written after empty rises, no byte lost.
REQ-033 fifo_full[0]=1 mid-payload for 4 cycles -> busy=1, write_enb=0 during full, held byte written once after release.
REQ-034 fifo_empty[1]=0, rd_en[1]=0 for 30 cycles -> soft_rst[1] single pulse at cycle 30; rd_en[1]=1 at cycle 29 -> no pulse.
REQ-035 Header addr3, 4 bytes pkt_valid=1 then parity -> no write_enb, busy=0, back to DECODE_ADDRESS; next valid packet routed correctly.

Source files
------------

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the packet router controller:
//   - NUM_PORTS     : number of destination FIFOs (fixed at 3)
//   - ADDR_INVALID  : header address with no FIFO behind it (packet dropped)
//   - header field positions (address in [1:0], payload length in [7:2])
//   - state_t and the FSM state encodings
//   - port_onehot() : address to one-hot port mask (zero for ADDR_INVALID)
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int NUM_PORTS = 3;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Header byte layout
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    // FSM encoding kept as plain constants so older tools and waveform
    // scripts that match on raw values keep working.
    typedef logic [2:0] state_t;

    localparam state_t DECODE_ADDRESS     = 3'd0;
    localparam state_t WAIT_TILL_EMPTY    = 3'd1;
    localparam state_t LOAD_FIRST_DATA    = 3'd2;
    localparam state_t LOAD_DATA          = 3'd3;
    localparam state_t FIFO_FULL_STATE    = 3'd4;
    localparam state_t CHECK_PARITY_ERROR = 3'd5;
    localparam state_t DROP_PACKET        = 3'd6;

    // The invalid address shifts out of the 3-bit window and yields an
    // all-zero mask, so it can never select a FIFO.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] addr);
        logic [3:0] dec;
        dec = 4'b0001 << addr;
        return dec[NUM_PORTS-1:0];
    endfunction

endpackage

// File: rtl/router_ctrl_timeout.sv
// -----------------------------------------------------------------------------
// router_ctrl_timeout
// Watchdog for one destination FIFO. Counts cycles in which the FIFO holds
// data but its reader is idle; when the count reaches TIMEOUT the port's
// soft reset pulses for exactly one cycle and the count restarts.
//
// Ports:
//   clk      in  1  rising-edge clock
//   rstn     in  1  asynchronous active-low reset
//   vld      in  1  FIFO holds data
//   rd_en    in  1  reader is draining the FIFO this cycle
//   soft_rst out 1  one-cycle soft reset pulse for this FIFO
// -----------------------------------------------------------------------------
module router_ctrl_timeout #(
    parameter int TIMEOUT = 30
) (
    input  logic clk,
    input  logic rstn,
    input  logic vld,
    input  logic rd_en,
    output logic soft_rst
);

    localparam int            CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] idle_cnt;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt <= '0;
        end else if (idle_cnt == LIMIT) begin
            // Pulse cycle: restart so the pulse is a single cycle wide.
            idle_cnt <= '0;
        end else if (vld && !rd_en) begin
            idle_cnt <= idle_cnt + CW'(1);
        end else begin
            idle_cnt <= '0;
        end
    end

    assign soft_rst = (idle_cnt == LIMIT);

endmodule

// File: rtl/router_ctrl.sv
// -----------------------------------------------------------------------------
// router_ctrl
// Control FSM of a 1-to-3 packet router. Accepts a byte stream from the
// source (header, payload bytes, then a parity byte marked by pkt_valid=0),
// steers it into the addressed destination FIFO and runs a per-port idle
// watchdog that soft-resets FIFOs nobody is reading.
//
// Optional feature (macro ROUTER_CTRL_PARITY_CHK_EN):
//   defined   : running XOR over header+payload is compared with the parity
//               byte; err is set after the CHECK_PARITY_ERROR cycle and held
//               until the next header is accepted.
//   undefined : no parity logic, err tied low, CHECK_PARITY_ERROR unused.
//
// Ports:
//   clk        in  1  rising-edge clock
//   rstn       in  1  asynchronous active-low reset
//   pkt_valid  in  1  source byte valid (low marks the parity byte)
//   data_in    in  8  source byte (header: [1:0] addr, [7:2] length)
//   fifo_full  in  3  per-FIFO full flags
//   fifo_empty in  3  per-FIFO empty flags
//   rd_en      in  3  per-FIFO read enables from the destinations
//   busy       out 1  source must hold its current byte
//   dout       out 8  FIFO write data (zero when nothing is written)
//   write_enb  out 3  one-hot FIFO write strobe
//   lfd_state  out 1  header tag, high in the cycle before the header write
//   soft_rst   out 3  per-FIFO one-cycle soft reset
//   vld_out    out 3  per-FIFO data available
//   err        out 1  parity error flag
// -----------------------------------------------------------------------------
module router_ctrl #(
    parameter int NUM_PORTS = 3,
    parameter int TIMEOUT   = 30
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 pkt_valid,
    input  logic [7:0]           data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] rd_en,
    output logic                 busy,
    output logic [7:0]           dout,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 lfd_state,
    output logic [NUM_PORTS-1:0] soft_rst,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic                 err
);

    import router_pkg::*;

    state_t               state;
    state_t               next_state;
    logic [7:0]           hdr_reg;
    logic [1:0]           addr_reg;

    logic [1:0]           in_addr;
    logic                 in_empty;
    logic [NUM_PORTS-1:0] port_sel;
    logic                 port_full;
    logic                 port_empty;
    logic                 port_srst;
    logic                 hdr_accept;
    logic                 wr_req;

    // -------------------------------------------------------------------------
    // Per-port status seen through the latched address
    // -------------------------------------------------------------------------
    assign in_addr    = data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign in_empty   = |(fifo_empty & port_onehot(in_addr));
    assign port_sel   = port_onehot(addr_reg);
    assign port_full  = |(fifo_full  & port_sel);
    assign port_empty = |(fifo_empty & port_sel);
    assign port_srst  = |(soft_rst   & port_sel);
    assign hdr_accept = (state == DECODE_ADDRESS) && pkt_valid;

    // -------------------------------------------------------------------------
    // Next state and datapath controls
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        wr_req     = 1'b0;
        dout       = 8'h00;

        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (in_addr == ADDR_INVALID) begin
                        next_state = DROP_PACKET;
                    end else if (in_empty) begin
                        next_state = LOAD_FIRST_DATA;
                    end else begin
                        next_state = WAIT_TILL_EMPTY;
                    end
                end
            end

            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (port_srst) begin
                    next_state = DECODE_ADDRESS;
                end else if (port_empty) begin
                    next_state = LOAD_FIRST_DATA;
                end
            end

            LOAD_FIRST_DATA: begin
                busy = 1'b1;
                if (port_srst) begin
                    next_state = DECODE_ADDRESS;
                end else begin
                    wr_req     = 1'b1;
                    dout       = hdr_reg;
                    next_state = LOAD_DATA;
                end
            end

            LOAD_DATA: begin
                // Only a full FIFO stalls the source; the byte on data_in
                // stays put until the FIFO drains.
                busy = port_full;
                if (port_srst) begin
                    next_state = DECODE_ADDRESS;
                end else if (port_full) begin
                    next_state = FIFO_FULL_STATE;
                end else begin
                    wr_req = 1'b1;
                    dout   = data_in;
                    if (!pkt_valid) begin
`ifdef ROUTER_CTRL_PARITY_CHK_EN
                        next_state = CHECK_PARITY_ERROR;
`else
                        next_state = DECODE_ADDRESS;
`endif
                    end
                end
            end

            FIFO_FULL_STATE: begin
                busy = 1'b1;
                if (port_srst) begin
                    next_state = DECODE_ADDRESS;
                end else if (!port_full) begin
                    next_state = LOAD_DATA;
                end
            end

            CHECK_PARITY_ERROR: begin
                busy       = 1'b1;
                next_state = DECODE_ADDRESS;
            end

            DROP_PACKET: begin
                // Bytes are consumed and discarded; the parity byte
                // (pkt_valid low) ends the packet.
                if (!pkt_valid) begin
                    next_state = DECODE_ADDRESS;
                end
            end

            default: begin
                next_state = DECODE_ADDRESS;
            end
        endcase
    end

    assign write_enb = wr_req ? port_sel : '0;

    // The FIFOs register this tag internally, so it leads the header write
    // by one cycle. Held low in reset so a byte sitting on data_in during
    // reset is never tagged as a header.
    assign lfd_state = rstn && (next_state == LOAD_FIRST_DATA);

    // -------------------------------------------------------------------------
    // State, header and address registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= DECODE_ADDRESS;
            hdr_reg  <= 8'h00;
            addr_reg <= 2'b00;
        end else begin
            state <= next_state;
            if (hdr_accept) begin
                hdr_reg  <= data_in;
                addr_reg <= in_addr;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Parity checking
    // -------------------------------------------------------------------------
`ifdef ROUTER_CTRL_PARITY_CHK_EN
    logic [7:0] parity_acc;
    logic [7:0] parity_rx;
    logic       err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            parity_acc <= 8'h00;
            parity_rx  <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            if (hdr_accept) begin
                parity_acc <= data_in;
                err_q      <= 1'b0;
            end else if ((state == LOAD_DATA) && wr_req && pkt_valid) begin
                parity_acc <= parity_acc ^ data_in;
            end

            if ((state == LOAD_DATA) && wr_req && !pkt_valid) begin
                parity_rx <= data_in;
            end

            if (state == CHECK_PARITY_ERROR) begin
                err_q <= (parity_acc != parity_rx);
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Per-port availability and idle watchdogs
    // -------------------------------------------------------------------------
    assign vld_out = ~fifo_empty;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_watchdog
        router_ctrl_timeout #(
            .TIMEOUT (TIMEOUT)
        ) u_timeout (
            .clk      (clk),
            .rstn     (rstn),
            .vld      (vld_out[i]),
            .rd_en    (rd_en[i]),
            .soft_rst (soft_rst[i])
        );
    end

endmodule

// File: tb/tb_router_ctrl.sv
// -----------------------------------------------------------------------------
// tb_router_ctrl
// Directed bench for router_ctrl. Inputs change 1 ns after the rising edge,
// outputs are sampled 1 ns later. Expected values are worked out by hand
// from the controller's cycle behaviour.
// -----------------------------------------------------------------------------
module tb_router_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] rd_en;
    logic       busy;
    logic [7:0] dout;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic [2:0] soft_rst;
    logic [2:0] vld_out;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_ctrl #(
        .NUM_PORTS (3),
        .TIMEOUT   (30)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .rd_en      (rd_en),
        .busy       (busy),
        .dout       (dout),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .soft_rst   (soft_rst),
        .vld_out    (vld_out),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive the source byte, check the combinational
    // outputs, then advance to 1 ns after the next rising edge.
    task automatic cyc(input string tag, input logic pv, input logic [7:0] din,
                       input logic e_busy, input logic [2:0] e_we,
                       input logic [7:0] e_dout, input logic e_lfd);
        pkt_valid = pv;
        data_in   = din;
        #1;
        check({tag, ".busy"}, busy, e_busy);
        check({tag, ".we"}, write_enb, e_we);
        check({tag, ".dout"}, dout, e_dout);
        check({tag, ".lfd"}, lfd_state, e_lfd);
        @(posedge clk);
        #1;
    endtask

`ifdef ROUTER_CTRL_PARITY_CHK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    initial begin
        // ---------------- reset state ----------------
        rstn       = 1'b0;
        pkt_valid  = 1'b1;
        data_in    = 8'h0D;
        fifo_full  = 3'b000;
        fifo_empty = 3'b110;
        rd_en      = 3'b000;
        #2;
        check("rst.busy", busy, 1'b0);
        check("rst.we", write_enb, 3'b000);
        check("rst.dout", dout, 8'h00);
        check("rst.lfd", lfd_state, 1'b0);
        check("rst.srst", soft_rst, 3'b000);
        check("rst.err", err, 1'b0);
        check("rst.vld", vld_out, 3'b001);
        pkt_valid  = 1'b0;
        fifo_empty = 3'b111;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- good packet to port 1 ----------------
        // parity = 0D ^ 11 ^ 22 ^ 33 = 0D
        cyc("t1_hdr", 1'b1, 8'h0D, 1'b0, 3'b000, 8'h00, 1'b1);
        cyc("t1_lfd", 1'b1, 8'h11, 1'b1, 3'b010, 8'h0D, 1'b0);
        cyc("t1_p0",  1'b1, 8'h11, 1'b0, 3'b010, 8'h11, 1'b0);
        cyc("t1_p1",  1'b1, 8'h22, 1'b0, 3'b010, 8'h22, 1'b0);
        cyc("t1_p2",  1'b1, 8'h33, 1'b0, 3'b010, 8'h33, 1'b0);
        cyc("t1_par", 1'b0, 8'h0D, 1'b0, 3'b010, 8'h0D, 1'b0);
`ifdef ROUTER_CTRL_PARITY_CHK_EN
        cyc("t1_chk", 1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0);
`endif
        check("t1_err", err, 1'b0);
        cyc("t1_idle", 1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0);

        // ---------------- same packet, wrong parity byte ----------------
        cyc("t2_hdr", 1'b1, 8'h0D, 1'b0, 3'b000, 8'h00, 1'b1);
        cyc("t2_lfd", 1'b1, 8'h11, 1'b1, 3'b010, 8'h0D, 1'b0);
        cyc("t2_p0",  1'b1, 8'h11, 1'b0, 3'b010, 8'h11, 1'b0);
        cyc("t2_p1",  1'b1, 8'h22, 1'b0, 3'b010, 8'h22, 1'b0);
        cyc("t2_p2",  1'b1, 8'h33, 1'b0, 3'b010, 8'h33, 1'b0);
        cyc("t2_par", 1'b0, 8'h00, 1'b0, 3'b010, 8'h00, 1'b0);
`ifdef ROUTER_CTRL_PARITY_CHK_EN
        cyc("t2_chk", 1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0);
`endif
        check("t2_err", err, PAR_EN);
        cyc("t2_idle", 1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0);
        check("t2_err_hold", err, PAR_EN);

        // ---------------- port 2 busy for 5 cycles ----------------
        // header 0A = addr 2, len 2; parity = 0A ^ 44 = 4E
        fifo_empty = 3'b011;
        cyc("t3_hdr", 1'b1, 8'h0A, 1'b0, 3'b000, 8'h00, 1'b0);
        check("t3_err_clr", err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc("t3_wait", 1'b1, 8'h44, 1'b1, 3'b000, 8'h00, 1'b0);
        end
        fifo_empty = 3'b111;
        cyc("t3_go",  1'b1, 8'h44, 1'b1, 3'b000, 8'h00, 1'b1);
        cyc("t3_lfd", 1'b1, 8'h44, 1'b1, 3'b100, 8'h0A, 1'b0);
        cyc("t3_p0",  1'b1, 8'h44, 1'b0, 3'b100, 8'h44, 1'b0);
        cyc("t3_par", 1'b0, 8'h4E, 1'b0, 3'b100, 8'h4E, 1'b0);
`ifdef ROUTER_CTRL_PARITY_CHK_EN
        cyc("t3_chk", 1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0);
`endif
        check("t3_err", err, 1'b0);

        // ---------------- port 0 full for 4 cycles mid-payload ----------------
        // header 08 = addr 0, len 2; parity = 08 ^ 55 ^ 66 = 3B
        cyc("t4_hdr", 1'b1, 8'h08, 1'b0, 3'b000, 8'h00, 1'b1);
        cyc("t4_lfd", 1'b1, 8'h55, 1'b1, 3'b001, 8'h08, 1'b0);
        cyc("t4_p0",  1'b1, 8'h55, 1'b0, 3'b001, 8'h55, 1'b0);
        fifo_full = 3'b001;
        cyc("t4_full", 1'b1, 8'h66, 1'b1, 3'b000, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc("t4_hold", 1'b1, 8'h66, 1'b1, 3'b000, 8'h00, 1'b0);
        end
        fifo_full = 3'b000;
        cyc("t4_rel", 1'b1, 8'h66, 1'b1, 3'b000, 8'h00, 1'b0);
        cyc("t4_p1",  1'b1, 8'h66, 1'b0, 3'b001, 8'h66, 1'b0);
        cyc("t4_par", 1'b0, 8'h3B, 1'b0, 3'b001, 8'h3B, 1'b0);
`ifdef ROUTER_CTRL_PARITY_CHK_EN
        cyc("t4_chk", 1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0);
`endif
        check("t4_err", err, 1'b0);

        // ---------------- watchdog: port 1 unread for 30 cycles ----------------
        pkt_valid  = 1'b0;
        fifo_empty = 3'b101;
        rd_en      = 3'b000;
        #1;
        check("t5_vld", vld_out, 3'b010);
        check("t5_srst0", soft_rst, 3'b000);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            check("t5_srst", soft_rst, (k == 30) ? 3'b010 : 3'b000);
        end

        // read at cycle 29 restarts the count: no pulse
        fifo_empty = 3'b111;
        @(posedge clk);
        #1;
        fifo_empty = 3'b101;
        for (int k = 1; k <= 35; k++) begin
            rd_en = (k == 29) ? 3'b010 : 3'b000;
            @(posedge clk);
            #1;
            check("t5_nopulse", soft_rst, 3'b000);
        end
        rd_en      = 3'b000;
        fifo_empty = 3'b111;
        @(posedge clk);
        #1;

        // ---------------- soft reset aborts a waiting packet ----------------
        fifo_empty = 3'b101;
        pkt_valid  = 1'b1;
        data_in    = 8'h05;
        #1;
        check("t6_hdr.lfd", lfd_state, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            data_in = 8'h77;
            #1;
            check("t6_wait.busy", busy, 1'b1);
            check("t6_wait.srst", soft_rst, (k == 30) ? 3'b010 : 3'b000);
        end
        @(posedge clk);
        #1;
        pkt_valid  = 1'b0;
        fifo_empty = 3'b111;
        #1;
        check("t6_abort.busy", busy, 1'b0);
        check("t6_abort.we", write_enb, 3'b000);
        check("t6_abort.lfd", lfd_state, 1'b0);
        @(posedge clk);
        #1;

        // ---------------- invalid address dropped, next packet routed ----------------
        cyc("t7_hdr", 1'b1, 8'h03, 1'b0, 3'b000, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc("t7_drop", 1'b1, 8'hF1, 1'b0, 3'b000, 8'h00, 1'b0);
        end
        cyc("t7_par",  1'b0, 8'h5A, 1'b0, 3'b000, 8'h00, 1'b0);
        // header 0D then AA, parity = 0D ^ AA = A7
        cyc("t7_hdr2", 1'b1, 8'h0D, 1'b0, 3'b000, 8'h00, 1'b1);
        cyc("t7_lfd",  1'b1, 8'hAA, 1'b1, 3'b010, 8'h0D, 1'b0);
        cyc("t7_p0",   1'b1, 8'hAA, 1'b0, 3'b010, 8'hAA, 1'b0);
        cyc("t7_par2", 1'b0, 8'hA7, 1'b0, 3'b010, 8'hA7, 1'b0);
`ifdef ROUTER_CTRL_PARITY_CHK_EN
        cyc("t7_chk",  1'b0, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0);
`endif
        check("t7_err", err, 1'b0);

        // ---------------- reset mid-packet ----------------
        cyc("t8_hdr", 1'b1, 8'h0E, 1'b0, 3'b000, 8'h00, 1'b1);
        cyc("t8_lfd", 1'b1, 8'h21, 1'b1, 3'b100, 8'h0E, 1'b0);
        rstn = 1'b0;
        #1;
        check("t8_rst.busy", busy, 1'b0);
        check("t8_rst.we", write_enb, 3'b000);
        check("t8_rst.dout", dout, 8'h00);
        check("t8_rst.lfd", lfd_state, 1'b0);
        check("t8_rst.srst", soft_rst, 3'b000);
        check("t8_rst.err", err, 1'b0);
        @(negedge clk);
        pkt_valid = 1'b0;
        rstn      = 1'b1;
        @(posedge clk);
        #1;
        cyc("t8_idle", 1'b0, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0);
        cyc("t8_hdr2", 1'b1, 8'h0E, 1'b0, 3'b000, 8'h00, 1'b1);
        cyc("t8_lfd2", 1'b1, 8'h21, 1'b1, 3'b100, 8'h0E, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
